apb_wait_slave: RTL

APB_WAIT_SLAVE -- requirements
Module: apb_wait_slave

---
 rtl/apb_wait_slave.sv | 139 +++++++++++++
 1 files changed

// File: rtl/apb_wait_slave.sv
// APB slave with a byte-wide register file and a fixed number of wait states per transfer.
// Outputs are registered and decoded from state; out-of-range addresses answer with pslverr.
module apb_wait_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [7:0]        err_count
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]        CNT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic [7:0]          err_count_q, err_count_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic                enter_acc;
  logic                acc_err;
  logic                acc_write;
  logic [ADDR_W-1:0]   acc_addr;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    err_count_d = err_count_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = '0;
    mem_we      = 1'b0;
    enter_acc   = 1'b0;
    acc_addr    = addr_q;
    acc_write   = write_q;

    unique case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          addr_d    = paddr;
          write_d   = pwrite;
          wdata_d   = pwdata;
          acc_addr  = paddr;
          acc_write = pwrite;
          if (WAIT_STATES == 0) begin
            enter_acc = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!psel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          enter_acc = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        // A deselected access phase is an abort: no commit, no error accounting.
        if (psel) begin
          mem_we = write_q && penable && !pslverr_q;
          if (pslverr_q && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    acc_err = ({1'b0, acc_addr} >= DEPTH_C);
    // Response is precomputed on the edge that enters ACCESS so outputs stay registered.
    if (enter_acc) begin
      state_d   = S_ACCESS;
      pready_d  = 1'b1;
      pslverr_d = acc_err;
      if (!acc_write && !acc_err) prdata_d = mem_q[acc_addr[IDX_W-1:0]];
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      err_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      err_count_q <= err_count_d;
      if (mem_we) mem_q[addr_q[IDX_W-1:0]] <= wdata_q;
    end
  end

  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign prdata    = prdata_q;
  assign err_count = err_count_q;

endmodule
